// File: rtl/sensor_pkg.sv
// sensor_pkg: shared state encoding, config offsets and widths
// for the linear image sensor controller.
package sensor_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CFG,
      S_INTEG,
      S_WAIT_SP,
      S_DATA,
      S_BLANK,
      S_DONE
   } state_t;

   localparam int CNT_W  = 32;
   localparam int FRM_W  = 16;
   localparam int CFG_AW = 8;
   localparam int CFG_DW = 32;

   localparam logic [CFG_AW-1:0] OFF_INTEG  = 8'd1;
   localparam logic [CFG_AW-1:0] OFF_BLANK  = 8'd2;
   localparam logic [CFG_AW-1:0] OFF_FRAMES = 8'd3;

   function automatic logic [FRM_W-1:0] sat_inc(input logic [FRM_W-1:0] v);
      return (&v) ? v : v + FRM_W'(1);
   endfunction

endpackage

// File: rtl/sensor_cfg_fetch.sv
// sensor_cfg_fetch: three back-to-back config reads while active,
// latched one cycle after each strobe; cfg_valid marks the last word.
module sensor_cfg_fetch
   import sensor_pkg::*;
#(
   parameter logic [CFG_AW-1:0] CFG_BASE = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              active,
   input  logic [CFG_DW-1:0] cfg_ram_din,
   output logic              cfg_ram_rd_o,
   output logic [CFG_AW-1:0] cfg_ram_addr_o,
   output logic [CFG_DW-1:0] integ,
   output logic [CFG_DW-1:0] blank,
   output logic [CFG_DW-1:0] frames,
   output logic              cfg_valid
);

   logic [1:0]        step;
   logic [CFG_AW-1:0] off;

   always_ff @(posedge clk) begin
      if (rst || !active) begin
         step <= '0;
      end else if (step != 2'd3) begin
         step <= step + 2'd1;
      end
   end

   always_comb begin
      off = '0;
      case (step)
         2'd0:    off = OFF_INTEG;
         2'd1:    off = OFF_BLANK;
         2'd2:    off = OFF_FRAMES;
         default: off = '0;
      endcase
   end

   assign cfg_ram_rd_o   = active && (step != 2'd3);
   assign cfg_ram_addr_o = cfg_ram_rd_o ? CFG_BASE + off : '0;
   assign cfg_valid      = active && (step == 2'd3);

   // data for the strobe of step n arrives while step is n+1
   always_ff @(posedge clk) begin
      if (rst) begin
         integ  <= '0;
         blank  <= '0;
         frames <= '0;
      end else if (active) begin
         case (step)
            2'd1:    integ  <= cfg_ram_din;
            2'd2:    blank  <= cfg_ram_din;
            2'd3:    frames <= cfg_ram_din;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/linear_sensor_ctrl.sv
// linear_sensor_ctrl: multi-frame integrate / start-pulse / readout /
// blanking sequencer for G11620-class linear sensors with pixel stream.
module linear_sensor_ctrl
   import sensor_pkg::*;
#(
   parameter int              PIX_NUM    = 512,
   parameter int              ADC_W      = 16,
   parameter int              SP_TIMEOUT = 4096,
   parameter logic [CFG_AW-1:0] CFG_BASE = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_in,
   input  logic              soft_reset_in,
   output logic              sensor_reset_o,
   output logic              sensor_clk_o,
   input  logic              ad_sp,
   input  logic [ADC_W-1:0]  adc_din,
   output logic              cfg_ram_rd_o,
   output logic [CFG_AW-1:0] cfg_ram_addr_o,
   input  logic [CFG_DW-1:0] cfg_ram_din,
   output logic [ADC_W-1:0]  pix_data_o,
   output logic              pix_valid_o,
   output logic              pix_first_o,
   output logic              pix_last_o,
   output logic [FRM_W-1:0]  frame_cnt_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              timeout_o
);

   localparam int PIX_W = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
   localparam logic [PIX_W-1:0] PIX_END = PIX_W'(PIX_NUM - 1);
   localparam logic [CNT_W-1:0] SP_END  = CNT_W'(SP_TIMEOUT - 1);

   state_t             state, state_nxt;
   logic               start_q, start_rise;
   logic [CNT_W-1:0]   cnt;
   logic [PIX_W-1:0]   pix_cnt;
   logic [CFG_DW-1:0]  integ, blank, frames, integ_eff;
   logic               cfg_valid;
   logic [FRM_W-1:0]   frm_inc;
   logic               frame_end, to_evt;
   state_t             line_next;
   logic               valid_q, first_q, last_q;

   sensor_cfg_fetch #(
      .CFG_BASE (CFG_BASE)
   ) u_fetch (
      .clk            (clk),
      .rst            (rst),
      .active         (state == S_CFG),
      .cfg_ram_din    (cfg_ram_din),
      .cfg_ram_rd_o   (cfg_ram_rd_o),
      .cfg_ram_addr_o (cfg_ram_addr_o),
      .integ          (integ),
      .blank          (blank),
      .frames         (frames),
      .cfg_valid      (cfg_valid)
   );

   assign start_rise = start_in && !start_q;
   assign integ_eff  = (integ == '0) ? CFG_DW'(1) : integ;
   assign frm_inc    = sat_inc(frame_cnt_o);
   assign line_next  = (frames == '0 ||
                        {{(CFG_DW-FRM_W){1'b0}}, frm_inc} < frames)
                       ? S_INTEG : S_DONE;

   always_comb begin
      state_nxt = state;
      frame_end = 1'b0;
      to_evt    = 1'b0;
      if (state != S_IDLE && soft_reset_in) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:  if (start_rise) state_nxt = S_CFG;
            S_CFG:   if (cfg_valid) state_nxt = S_INTEG;
            S_INTEG: if (cnt == integ_eff - 32'd1) state_nxt = S_WAIT_SP;
            S_WAIT_SP: begin
               if (ad_sp) begin
                  state_nxt = S_DATA;
               end else if (cnt == SP_END) begin
                  to_evt    = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
            S_DATA: begin
               // zero blanking skips the BLANK state entirely
               if (pix_cnt == PIX_END) begin
                  if (blank == '0) begin
                     frame_end = 1'b1;
                     state_nxt = line_next;
                  end else begin
                     state_nxt = S_BLANK;
                  end
               end
            end
            S_BLANK: begin
               if (cnt == blank - 32'd1) begin
                  frame_end = 1'b1;
                  state_nxt = line_next;
               end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         start_q     <= 1'b0;
         cnt         <= '0;
         pix_cnt     <= '0;
         frame_cnt_o <= '0;
         pix_data_o  <= '0;
         valid_q     <= 1'b0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         done_o      <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         state   <= state_nxt;
         start_q <= start_in;
         cnt     <= (state_nxt != state || state == S_IDLE)
                    ? '0 : cnt + 32'd1;
         pix_cnt <= (state == S_DATA && state_nxt == S_DATA)
                    ? pix_cnt + PIX_W'(1) : '0;
         if (state == S_IDLE && start_rise) begin
            frame_cnt_o <= '0;
         end else if (frame_end) begin
            frame_cnt_o <= frm_inc;
         end
         if (state == S_DATA) pix_data_o <= adc_din;
         valid_q   <= (state == S_DATA) && !soft_reset_in;
         first_q   <= (state == S_DATA) && !soft_reset_in && pix_cnt == '0;
         last_q    <= (state == S_DATA) && !soft_reset_in && pix_cnt == PIX_END;
         done_o    <= (state == S_DONE) && !soft_reset_in;
         timeout_o <= to_evt;
      end
   end

   assign sensor_clk_o   = ~clk;
   assign busy_o         = (state != S_IDLE);
   assign sensor_reset_o = (state == S_INTEG) && !soft_reset_in;
   assign pix_valid_o    = valid_q && !soft_reset_in;
   assign pix_first_o    = first_q && !soft_reset_in;
   assign pix_last_o     = last_q && !soft_reset_in;

endmodule

// File: tb/tb_linear_sensor_ctrl.sv
// tb_linear_sensor_ctrl: directed runs of the sensor controller against
// a config RAM model and a ramp ADC, with hand-derived expectations.
module tb_linear_sensor_ctrl;

   localparam int PIX = 8;
   localparam int SPT = 16;
   localparam logic [7:0] BASE = 8'h20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_in = 1'b0;
   logic        soft_reset_in = 1'b0;
   logic        ad_sp = 1'b0;
   logic [15:0] adc_din;
   logic [31:0] cfg_ram_din = '0;
   logic        sensor_reset_o, sensor_clk_o, cfg_ram_rd_o;
   logic [7:0]  cfg_ram_addr_o;
   logic [15:0] pix_data_o, frame_cnt_o;
   logic        pix_valid_o, pix_first_o, pix_last_o;
   logic        busy_o, done_o, timeout_o;

   logic [31:0] cfg_mem [256];
   int cyc = 0;
   int total = 0, bad = 0;
   int n_rd = 0, n_addr_bad = 0, n_rhi = 0, n_pix = 0, n_pix_bad = 0;
   int n_pos_bad = 0, n_lines = 0, n_done = 0, n_to = 0;
   int last_cyc = 0, done_cyc = 0, idx = 0;
   int s_rd, s_rhi, s_pix, s_pix_bad, s_pos_bad, s_lines, s_done, s_to;
   int wsp_cyc = 0, seen = 0;

   linear_sensor_ctrl #(
      .PIX_NUM    (PIX),
      .ADC_W      (16),
      .SP_TIMEOUT (SPT),
      .CFG_BASE   (BASE)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start_in       (start_in),
      .soft_reset_in  (soft_reset_in),
      .sensor_reset_o (sensor_reset_o),
      .sensor_clk_o   (sensor_clk_o),
      .ad_sp          (ad_sp),
      .adc_din        (adc_din),
      .cfg_ram_rd_o   (cfg_ram_rd_o),
      .cfg_ram_addr_o (cfg_ram_addr_o),
      .cfg_ram_din    (cfg_ram_din),
      .pix_data_o     (pix_data_o),
      .pix_valid_o    (pix_valid_o),
      .pix_first_o    (pix_first_o),
      .pix_last_o     (pix_last_o),
      .frame_cnt_o    (frame_cnt_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .timeout_o      (timeout_o)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   assign adc_din = 16'h1000 + cyc[15:0];

   always @(posedge clk) begin
      if (cfg_ram_rd_o) cfg_ram_din <= cfg_mem[cfg_ram_addr_o];
   end

   // stream monitor; the pixel seen in cycle c was sampled in cycle c-1
   always @(negedge clk) begin
      if (cfg_ram_rd_o) begin
         n_rd <= n_rd + 1;
         if (cfg_ram_addr_o < BASE + 8'd1 || cfg_ram_addr_o > BASE + 8'd3)
            n_addr_bad <= n_addr_bad + 1;
      end
      if (sensor_reset_o) n_rhi <= n_rhi + 1;
      if (done_o) begin
         n_done   <= n_done + 1;
         done_cyc <= cyc;
      end
      if (timeout_o) n_to <= n_to + 1;
      if (!pix_valid_o && (pix_first_o || pix_last_o))
         n_pos_bad <= n_pos_bad + 1;
      if (pix_valid_o) begin
         n_pix <= n_pix + 1;
         if (pix_data_o != 16'h1000 + cyc[15:0] - 16'd1)
            n_pix_bad <= n_pix_bad + 1;
         if (pix_first_o != (idx == 0) || pix_last_o != (idx == PIX - 1))
            n_pos_bad <= n_pos_bad + 1;
         idx <= pix_last_o ? 0 : idx + 1;
         if (pix_last_o) begin
            n_lines  <= n_lines + 1;
            last_cyc <= cyc;
         end
      end else if (!busy_o) begin
         idx <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic nsamp();
      @(negedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [31:0] i, input logic [31:0] b,
                          input logic [31:0] f);
      cfg_mem[BASE + 8'd1] = i;
      cfg_mem[BASE + 8'd2] = b;
      cfg_mem[BASE + 8'd3] = f;
   endtask

   task automatic snap();
      s_rd = n_rd; s_rhi = n_rhi; s_pix = n_pix; s_pix_bad = n_pix_bad;
      s_pos_bad = n_pos_bad; s_lines = n_lines; s_done = n_done; s_to = n_to;
   endtask

   task automatic pulse_start();
      start_in = 1'b1;
      nsamp();
      start_in = 1'b0;
   endtask

   // wait out one INTEG phase, then pulse ad_sp dly cycles into WAIT_SP
   task automatic do_line(input int dly);
      for (int i = 0; i < 100 && !sensor_reset_o; i++) nsamp();
      check("integ_seen", sensor_reset_o, 1);
      for (int i = 0; i < 100 && sensor_reset_o; i++) nsamp();
      check("integ_end", sensor_reset_o, 0);
      wsp_cyc = cyc;
      if (dly >= 0) begin
         repeat (dly) nsamp();
         ad_sp = 1'b1;
         nsamp();
         ad_sp = 1'b0;
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 300 && !done_o; i++) nsamp();
      check("done_seen", done_o, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      foreach (cfg_mem[i]) cfg_mem[i] = 32'd9;
      repeat (3) nsamp();
      check("rst_sres", sensor_reset_o, 0);
      check("rst_sclk", sensor_clk_o, 1);
      check("rst_rd", cfg_ram_rd_o, 0);
      check("rst_addr", cfg_ram_addr_o, 0);
      check("rst_data", pix_data_o, 0);
      check("rst_valid", {pix_valid_o, pix_first_o, pix_last_o}, 0);
      check("rst_frm", frame_cnt_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_pulses", {done_o, timeout_o}, 0);
      rst = 1'b0;
      repeat (2) nsamp();

      // single frame
      set_cfg(5, 3, 1);
      snap();
      pulse_start();
      check("t1_busy", busy_o, 1);
      do_line(2);
      wait_done();
      check("t1_busy_end", busy_o, 0);
      check("t1_rhi", n_rhi - s_rhi, 5);
      check("t1_pix", n_pix - s_pix, 8);
      check("t1_ramp", n_pix_bad - s_pix_bad, 0);
      check("t1_flags", n_pos_bad - s_pos_bad, 0);
      check("t1_lines", n_lines - s_lines, 1);
      check("t1_done_lat", done_cyc - last_cyc, 4);
      check("t1_frm", frame_cnt_o, 1);
      check("t1_rd", n_rd - s_rd, 3);

      // three frames from one config burst
      nsamp();
      set_cfg(5, 3, 3);
      snap();
      pulse_start();
      repeat (3) do_line(2);
      wait_done();
      repeat (5) nsamp();
      check("t2_rd", n_rd - s_rd, 3);
      check("t2_rhi", n_rhi - s_rhi, 15);
      check("t2_pix", n_pix - s_pix, 24);
      check("t2_ramp", n_pix_bad - s_pix_bad, 0);
      check("t2_lines", n_lines - s_lines, 3);
      check("t2_done", n_done - s_done, 1);
      check("t2_frm", frame_cnt_o, 3);

      // continuous, aborted in line 5 pixel 3
      set_cfg(2, 3, 0);
      snap();
      pulse_start();
      repeat (5) do_line(1);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         if (pix_valid_o) seen++;
         if (seen == 4) break;
         nsamp();
      end
      check("t3_px3", seen, 4);
      soft_reset_in = 1'b1;
      nsamp();
      check("t3_valid", pix_valid_o, 0);
      check("t3_last", pix_last_o, 0);
      check("t3_busy", busy_o, 0);
      check("t3_sres", sensor_reset_o, 0);
      soft_reset_in = 1'b0;
      repeat (5) nsamp();
      check("t3_frm", frame_cnt_o, 4);
      check("t3_lines", n_lines - s_lines, 4);
      check("t3_pix", n_pix - s_pix, 36);
      check("t3_flags", n_pos_bad - s_pos_bad, 0);
      check("t3_pulses", (n_done - s_done) + (n_to - s_to), 0);

      // ad_sp never arrives
      set_cfg(3, 1, 1);
      snap();
      pulse_start();
      do_line(-1);
      for (int i = 0; i < 40 && !timeout_o; i++) nsamp();
      check("t4_to_seen", timeout_o, 1);
      check("t4_to_lat", cyc - wsp_cyc, 16);
      check("t4_busy", busy_o, 0);
      repeat (4) nsamp();
      check("t4_to_cnt", n_to - s_to, 1);
      check("t4_pix", n_pix - s_pix, 0);
      check("t4_done", n_done - s_done, 0);

      // INTEG=0, BLANK=0, second start edge mid-run
      set_cfg(0, 0, 1);
      snap();
      pulse_start();
      repeat (2) nsamp();
      pulse_start();
      do_line(1);
      wait_done();
      check("t5_rhi", n_rhi - s_rhi, 1);
      check("t5_done_lat", done_cyc - last_cyc, 1);
      check("t5_pix", n_pix - s_pix, 8);
      check("t5_frm", frame_cnt_o, 1);
      repeat (8) nsamp();
      check("t5_rd", n_rd - s_rd, 3);
      check("t5_done", n_done - s_done, 1);
      check("t5_busy", busy_o, 0);

      // rst during DATA of line 2, then a clean run
      set_cfg(2, 1, 2);
      pulse_start();
      do_line(2);
      do_line(2);
      for (int i = 0; i < 20 && !pix_valid_o; i++) nsamp();
      check("t6_pix_seen", pix_valid_o, 1);
      rst = 1'b1;
      nsamp();
      check("t6_outs", {sensor_reset_o, cfg_ram_rd_o, pix_valid_o,
                        pix_first_o, pix_last_o, busy_o, done_o,
                        timeout_o}, 0);
      check("t6_data", pix_data_o, 0);
      check("t6_frm", frame_cnt_o, 0);
      rst = 1'b0;
      nsamp();
      set_cfg(4, 2, 1);
      snap();
      pulse_start();
      do_line(3);
      wait_done();
      check("t6_rd", n_rd - s_rd, 3);
      check("t6_pix", n_pix - s_pix, 8);
      check("t6_ramp", n_pix_bad - s_pix_bad, 0);
      check("t6_lines", n_lines - s_lines, 1);
      check("t6_frm2", frame_cnt_o, 1);
      check("addr_range", n_addr_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
